step_clk_conditioner: RTL and testbench
=======================================

// Module: step_clk_conditioner
// PURPOSE
//   Conditions a raw board push-button/switch into a clean single-step CPU clock.
//   Sits between the board inputs and the CPU core clock input on the board top.
//   Synchronises and debounces the raw level, then emits a one-cycle step pulse
//   and a clean step level per press. Counts steps for display/debug.
// PARAMETERS
//   DB_CYCLES  200000    stable cycles required to accept an edge (>=2)
//   CNT_W      16        width of step_count
//   AUTO_DIV   50000000  clk cycles per auto step (AUTO_RUN_EN builds only; >=2)
// PORTS
//   clk         in   1      board clock; only clock, all logic on posedge
//   rst         in   1      synchronous, active-high reset
//   btn_raw     in   1      raw asynchronous button/switch level, 1 = pressed
//   run_mode    in   1      1 = free-running auto step (port exists only with AUTO_RUN_EN)
//   step_pulse  out  1      one clk-cycle strobe per accepted step
//   step_level  out  1      clean level: 1 while debounced press is held
//   step_count  out  CNT_W  number of steps issued, wraps modulo 2^CNT_W
//   busy        out  1      1 whenever FSM is not in IDLE
// BEHAVIOUR
//   - Reset values: step_pulse=0, step_level=0, step_count=0, busy=1 (state LOCK),
//     db_cnt=0, synchroniser flops=0. Reset mid-operation aborts any press; no pulse.
//   - btn_raw passes a 2-flop synchroniser -> btn_s (2 cycles latency).
//   - db_cnt: increments while btn_s differs from the level the current state awaits;
//     clears to 0 on any cycle btn_s equals the awaited-against level (bounce restarts).
//   - FSM states / transitions:
//       LOCK     : waits for btn_s=0 for DB_CYCLES cycles -> IDLE. Held button at reset
//                  release therefore never produces a step.
//       IDLE     : btn_s=1 -> DB_PRESS (db_cnt starts).
//       DB_PRESS : btn_s=0 -> IDLE; db_cnt reaches DB_CYCLES-1 with btn_s=1 -> HELD.
//       HELD     : btn_s=0 -> DB_REL.
//       DB_REL   : btn_s=1 -> HELD; db_cnt reaches DB_CYCLES-1 with btn_s=0 -> IDLE.
//   - step_pulse = 1 exactly in the cycle FSM enters HELD from DB_PRESS (registered).
//     Never on DB_REL->HELD re-entry. Latency: 2+DB_CYCLES cycles after the last
//     raw edge of a clean press.
//   - step_count += 1 in the same cycle step_pulse is 1; all-ones wraps to 0.
//   - step_level = 1 in HELD and DB_REL, else 0 (registered with state).
//   - busy = (state != IDLE).
// CONFIGURATION
//   AUTO_RUN_EN defined:
//     - run_mode port present. While run_mode=1 and state=IDLE, a divider counts
//       0..AUTO_DIV-1; step_pulse=1 and step_count+=1 when it wraps to 0;
//       step_level=1 for divider values < AUTO_DIV/2.
//     - While run_mode=1, IDLE->DB_PRESS is inhibited (button presses ignored).
//     - run_mode 1->0: divider clears to 0 next cycle, step_level=0; no partial pulse.
//     - Reset clears divider to 0.
//   AUTO_RUN_EN undefined: no run_mode port, no divider logic, AUTO_DIV unused;
//     steps only from debounced presses.
// TESTING (bench: DB_CYCLES=4, CNT_W=4, AUTO_DIV=8)
//   1. rst=1 3 cycles, btn_raw=0 -> outputs 0, busy=1; busy=0 by 7th cycle after rst release.
//   2. From IDLE, btn_raw 0->1 held 20 cycles -> one step_pulse 6 cycles after edge,
//      step_count 0->1, step_level=1 until 6 cycles after release.
//   3. btn_raw toggles every 2 cycles for 12 cycles then stays 1 -> exactly one
//      step_pulse, 6 cycles after last edge; step_count +1.
//   4. 16 clean presses -> step_count 1..15 then 0 (wrap); 16 pulses total.
//   5. rst pulsed while in HELD, btn_raw held 1 -> no pulse, step_count=0; pulse only
//      after release >=6 cycles and new press.
//   6. AUTO_RUN_EN, run_mode=1 for 40 cycles from IDLE -> 5 pulses spaced 8 cycles,
//      step_count=5; presses ignored. Without AUTO_RUN_EN: builds, no run_mode port.

Source files
------------

// File: rtl/step_clk_conditioner_if.sv
// Board-side signal bundle for step_clk_conditioner.
// run_mode_i is present only when AUTO_RUN_EN is defined.
interface step_clk_conditioner_if #(
  parameter int CNT_W = 16
) ();
  logic             btn_raw_i;
`ifdef AUTO_RUN_EN
  logic             run_mode_i;
`endif
  logic             step_pulse_o;
  logic             step_level_o;
  logic [CNT_W-1:0] step_count_o;
  logic             busy_o;

`ifdef AUTO_RUN_EN
  modport slave  (input  btn_raw_i, run_mode_i,
                  output step_pulse_o, step_level_o, step_count_o, busy_o);
  modport master (output btn_raw_i, run_mode_i,
                  input  step_pulse_o, step_level_o, step_count_o, busy_o);
`else
  modport slave  (input  btn_raw_i,
                  output step_pulse_o, step_level_o, step_count_o, busy_o);
  modport master (output btn_raw_i,
                  input  step_pulse_o, step_level_o, step_count_o, busy_o);
`endif
endinterface

// File: rtl/step_clk_conditioner.sv
// step_clk_conditioner: turns a raw push-button level into a clean single-step
// clock: 2-flop synchroniser, debounce FSM, one-cycle step strobe, clean level
// and a wrapping step counter.
// Optional feature macro: AUTO_RUN_EN adds run_mode_i and a free-running
// auto-step divider of AUTO_DIV cycles per step.
module step_clk_conditioner #(
  parameter int DB_CYCLES = 200000,
  parameter int CNT_W     = 16,
  parameter int AUTO_DIV  = 50000000
) (
  input  logic                   clk,
  input  logic                   rst,
  step_clk_conditioner_if.slave  bus
);
  localparam int DBW = $clog2(DB_CYCLES);

  if (DB_CYCLES < 2 || AUTO_DIV < 2) begin : g_param_chk
    $error("step_clk_conditioner: DB_CYCLES and AUTO_DIV must be >= 2");
  end

  typedef enum logic [2:0] {LOCK, IDLE, DB_PRESS, HELD, DB_REL} state_t;

  state_t           state_q, state_d;
  logic             sync1_q, btn_s_q;
  logic [DBW-1:0]   db_cnt_q, db_cnt_d;
  logic             pulse_q, pulse_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ref_lvl, differs, db_done, auto_run;

`ifdef AUTO_RUN_EN
  localparam int DIVW = $clog2(AUTO_DIV);
  logic [DIVW-1:0]  div_q, div_d;
  logic             div_wrap;
  assign auto_run = bus.run_mode_i && (state_q == IDLE);
  assign div_wrap = (div_q == DIVW'(AUTO_DIV - 1));
`else
  assign auto_run = 1'b0;
`endif

  // Level each state is waiting to see disappear; db_cnt counts samples of the other level.
  assign ref_lvl = (state_q == LOCK) || (state_q == HELD) || (state_q == DB_REL);
  assign differs = (btn_s_q != ref_lvl);
  assign db_done = differs && (db_cnt_q == DBW'(DB_CYCLES - 1));

  // Two-flop synchroniser for the asynchronous button level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      btn_s_q <= 1'b0;
    end else begin
      sync1_q <= bus.btn_raw_i;
      btn_s_q <= sync1_q;
    end
  end

  // Next-state, debounce count, step strobe/count and clean level.
  always_comb begin
    state_d  = state_q;
    pulse_d  = 1'b0;
    count_d  = count_q;
    db_cnt_d = (differs && !db_done && !auto_run) ? DBW'(db_cnt_q + 1'b1) : '0;
    case (state_q)
      LOCK:     if (db_done) state_d = IDLE;
      IDLE:     if (btn_s_q && !auto_run) state_d = DB_PRESS;
      DB_PRESS: begin
        if (!btn_s_q) state_d = IDLE;
        else if (db_done) begin
          state_d = HELD;
          pulse_d = 1'b1;
          count_d = count_q + 1'b1;
        end
      end
      HELD:     if (!btn_s_q) state_d = DB_REL;
      DB_REL: begin
        if (btn_s_q) state_d = HELD;
        else if (db_done) state_d = IDLE;
      end
      default:  state_d = LOCK;
    endcase
    level_d = (state_d == HELD) || (state_d == DB_REL);
`ifdef AUTO_RUN_EN
    div_d = '0;
    if (auto_run) begin
      div_d   = div_wrap ? '0 : DIVW'(div_q + 1'b1);
      level_d = (div_d < DIVW'(AUTO_DIV / 2));
      if (div_wrap) begin
        pulse_d = 1'b1;
        count_d = count_q + 1'b1;
      end
    end
`endif
  end

  // State and output registers; reset parks in LOCK so a held button never steps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOCK;
      db_cnt_q <= '0;
      pulse_q  <= 1'b0;
      level_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      pulse_q  <= pulse_d;
      level_q  <= level_d;
      count_q  <= count_d;
    end
  end

`ifdef AUTO_RUN_EN
  // Auto-step divider; cleared whenever auto stepping is not active.
  always_ff @(posedge clk) begin
    if (rst) div_q <= '0;
    else     div_q <= div_d;
  end
`endif

  assign bus.step_pulse_o = pulse_q;
  assign bus.step_level_o = level_q;
  assign bus.step_count_o = count_q;
  assign bus.busy_o       = (state_q != IDLE);
endmodule

// File: tb/tb_step_clk_conditioner.sv
// Bench for step_clk_conditioner (DB_CYCLES=4, CNT_W=4, AUTO_DIV=8).
// The model tracks the accepted debounced level and the run length of
// disagreeing synchronised samples; outputs are compared every cycle.
module tb_step_clk_conditioner;
  localparam int DB_CYCLES = 4;
  localparam int CNT_W     = 4;
  localparam int AUTO_DIV  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic run_mode = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int tally = 0;

  always #5 clk = ~clk;

  step_clk_conditioner_if #(.CNT_W(CNT_W)) bus ();
  assign bus.btn_raw_i = btn;
`ifdef AUTO_RUN_EN
  assign bus.run_mode_i = run_mode;
`endif

  step_clk_conditioner #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W), .AUTO_DIV(AUTO_DIV)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model
  logic             m_ok = 1'b0;
  logic             m_s1, m_s2, s, m_idle;
  logic             m_acc, m_lock, m_pulse, m_level;
  int               m_run, m_div;
  logic [CNT_W-1:0] m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_acc = 1; m_lock = 1; m_run = 0;
      m_cnt = 0; m_pulse = 0; m_level = 0; m_div = 0; m_ok = 1;
    end else if (m_ok) begin
      s = m_s2; m_s2 = m_s1; m_s1 = btn;
      m_pulse = 0;
      m_idle = !m_lock && !m_acc && (m_run == 0);
      if (run_mode && m_idle) begin
        m_div = (m_div + 1) % AUTO_DIV;
        if (m_div == 0) begin m_pulse = 1; m_cnt = m_cnt + 1'b1; end
        m_level = (m_div < AUTO_DIV / 2);
      end else begin
        m_div = 0;
        if (s != m_acc) m_run++; else m_run = 0;
        if (m_run == DB_CYCLES) begin
          m_acc = s; m_run = 0;
          if (s) begin m_pulse = 1; m_cnt = m_cnt + 1'b1; end
          else m_lock = 0;
        end
        m_level = m_acc && !m_lock;
      end
    end
  end

  // Per-cycle compare against the model, plus a pulse tally for directed checks.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("pulse", 32'(bus.step_pulse_o), 32'(m_pulse));
      chk("level", 32'(bus.step_level_o), 32'(m_level));
      chk("count", 32'(bus.step_count_o), 32'(m_cnt));
      chk("busy",  32'(bus.busy_o), 32'(m_lock || m_acc || (m_run != 0)));
    end
    if (bus.step_pulse_o) tally++;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k, t0;
    // 1: reset state and lock-out exit
    cyc(3);
    chk("t1_rst_pulse", 32'(bus.step_pulse_o), 0);
    chk("t1_rst_level", 32'(bus.step_level_o), 0);
    chk("t1_rst_count", 32'(bus.step_count_o), 0);
    chk("t1_rst_busy",  32'(bus.busy_o), 1);
    rst = 0;
    cyc(7);
    chk("t1_idle_busy", 32'(bus.busy_o), 0);

    // 2: clean press, latency and release latency
    btn = 1;
    k = 0;
    while (!bus.step_pulse_o && k < 20) begin cyc(1); k++; end
    chk("t2_pulse_lat", 32'(k), 6);
    chk("t2_count", 32'(bus.step_count_o), 1);
    cyc(14);
    chk("t2_level_held", 32'(bus.step_level_o), 1);
    btn = 0;
    k = 0;
    while (bus.step_level_o && k < 20) begin cyc(1); k++; end
    chk("t2_rel_lat", 32'(k), 6);
    cyc(4);

    // 3: bouncing press yields exactly one step after the last edge
    t0 = tally;
    for (int i = 0; i < 6; i++) begin btn = ~btn; cyc(2); end
    btn = 1;
    k = 0;
    while (!bus.step_pulse_o && k < 20) begin cyc(1); k++; end
    chk("t3_pulse_lat", 32'(k), 6);
    cyc(10);
    chk("t3_pulses", 32'(tally - t0), 1);
    chk("t3_count", 32'(bus.step_count_o), 2);
    btn = 0;
    cyc(10);

    // 5: reset while held aborts the press; held button never steps
    btn = 1;
    cyc(12);
    chk("t5_held_level", 32'(bus.step_level_o), 1);
    t0 = tally;
    rst = 1; cyc(1); rst = 0;
    cyc(15);
    chk("t5_no_pulse", 32'(tally - t0), 0);
    chk("t5_count0", 32'(bus.step_count_o), 0);
    chk("t5_locked", 32'(bus.busy_o), 1);
    btn = 0;
    cyc(8);
    chk("t5_unlocked", 32'(bus.busy_o), 0);
    btn = 1;
    cyc(10);
    chk("t5_new_pulse", 32'(tally - t0), 1);
    chk("t5_count1", 32'(bus.step_count_o), 1);
    btn = 0;
    cyc(10);

    // 4: sixteen presses from zero wrap the counter
    rst = 1; cyc(2); rst = 0;
    cyc(8);
    t0 = tally;
    for (int i = 0; i < 16; i++) begin btn = 1; cyc(8); btn = 0; cyc(8); end
    chk("t4_pulses", 32'(tally - t0), 16);
    chk("t4_wrap", 32'(bus.step_count_o), 0);

`ifdef AUTO_RUN_EN
    // 6: auto-run for 40 cycles, button ignored
    t0 = tally;
    run_mode = 1;
    cyc(10); btn = 1; cyc(15); btn = 0; cyc(15);
    run_mode = 0;
    cyc(1);
    chk("t6_pulses", 32'(tally - t0), 5);
    chk("t6_count", 32'(bus.step_count_o), 5);
    chk("t6_level_off", 32'(bus.step_level_o), 0);
    cyc(5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
